// File: rtl/branch_resolve_bht.sv
// Branch resolution and flush controller with a 2-bit saturating-counter BHT.
// Fetch side: pred_taken is the MSB of the counter selected by fetch_pc.
// Execute side: a redirect is raised on a branch mispredict or any JAL/JALR.
// After a redirect, the FSM holds flush for SHADOW cycles, then hands the
// flush codes back to the hazard unit.
// Optional statistics counters are built when BHT_STATS_EN is defined.
module branch_resolve_bht #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int SHADOW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred,
  input  logic        ex_taken,
  input  logic [31:0] alu_target,
  input  logic        stall,
  input  logic [1:0]  flush_in,
  output logic        pc_sel,
  output logic [31:0] redirect_pc,
  output logic [1:0]  flush_if_id,
`ifdef BHT_STATS_EN
  output logic [1:0]  flush_id_ex,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
`else
  output logic [1:0]  flush_id_ex
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam bit         SH_EN     = (SHADOW > 0);
  localparam logic [2:0] SH_LOAD   = SH_EN ? 3'(SHADOW - 1) : 3'd0;

  typedef enum logic {S_IDLE, S_SHADOW} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sh_cnt_q, sh_cnt_d;
  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] fetch_idx, ex_idx;
  logic             is_br, is_jmp, idle, resolve, br_update, mispred, redir;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign is_br     = (ex_inst[6:0] == OP_BRANCH);
  assign is_jmp    = (ex_inst[6:0] == OP_JAL) | (ex_inst[6:0] == OP_JALR);
  assign idle      = (state_q == S_IDLE);
  // In SHADOW the EX instruction is on the wrong path, so nothing resolves.
  assign resolve   = idle & ex_valid & ~stall;
  assign br_update = resolve & is_br;
  assign mispred   = ex_pred ^ ex_taken;
  assign redir     = resolve & ((is_br & mispred) | is_jmp);

  // Lookup reads the registered table only: a same-cycle update to the
  // same index is not bypassed.
  assign pred_taken  = bht[fetch_idx][1];
  assign redirect_pc = (is_jmp | ex_taken) ? alu_target : ex_pc + 32'd4;

  // Saturating counter update for resolved conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (br_update) begin
      if (ex_taken && bht[ex_idx] != 2'b11)       bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!ex_taken && bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

  // FSM state and shadow down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sh_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end

  // Next state plus pc_sel / flush code selection.
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    pc_sel      = 1'b1;
    flush_if_id = flush_in;
    flush_id_ex = flush_in;
    case (state_q)
      S_IDLE: begin
        if (redir) begin
          pc_sel      = 1'b0;
          flush_if_id = 2'b11;
          flush_id_ex = 2'b11;
          if (SH_EN) begin
            state_d  = S_SHADOW;
            sh_cnt_d = SH_LOAD;
          end
        end else if (stall) begin
          flush_if_id = 2'b11;
          flush_id_ex = 2'b10;
        end
      end
      S_SHADOW: begin
        flush_if_id = 2'b11;
        flush_id_ex = 2'b11;
        if (sh_cnt_q == 3'd0) state_d  = S_IDLE;
        else                  sh_cnt_d = sh_cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BHT_STATS_EN
  // Saturating statistics over BHT-updating branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (br_update) begin
      if (branch_cnt != 32'hFFFF_FFFF)             branch_cnt  <= branch_cnt + 32'd1;
      if (mispred && mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

  // Address/instruction bits that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], ex_inst[31:7]};

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch-resolution and flush controller for the RISC-V 5-stage pipeline.
- Fetch side: indexed table of 2-bit saturating counters supplies `pred_taken`.
- Execute side: compares the carried prediction with the actual outcome, then drives the redirect and per-stage flush codes.
- After a redirect, a small FSM holds flush for a configurable number of shadow cycles, then returns to normal passthrough of the hazard unit's flush/stall.

## Interface
- `ENTRIES`, 16, number of BHT counters; power of two, 2..1024
- `IDX_W`, $clog2(ENTRIES), index width (derived, not overridden)
- `SHADOW`, 1, wrong-path cycles flushed after a redirect; 0..7
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_pc`  in  32  IF-stage PC
- `pred_taken`  out  1  combinational prediction: MSB of counter at `fetch_pc[IDX_W+1:2]`
- `ex_valid`  in  1  EX stage holds a real instruction
- `ex_inst`  in  32  EX-stage instruction word
- `ex_pc`  in  32  EX-stage PC
- `ex_pred`  in  1  prediction carried down with the instruction
- `ex_taken`  in  1  actual branch outcome from the ALU comparator
- `alu_target`  in  32  computed branch/jump target
- `stall`  in  1  load-use stall from the hazard unit
- `flush_in`  in  2  flush code from the hazard unit
- `pc_sel`  out  1  1 = fetch continues on the predicted path; 0 = take `redirect_pc`
- `redirect_pc`  out  32  `ex_taken ? alu_target : ex_pc + 4`; `alu_target` for JAL/JALR
- `flush_if_id`  out  2  IF/ID register flush code
- `flush_id_ex`  out  2  ID/EX register flush code
- `branch_cnt`, `mispred_cnt`  out  32 each  stats; present only with the macro below

## Operation
- Opcode decode on `ex_inst[6:0]`: BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111.
- Event `redir`, asserted only in IDLE with `ex_valid=1` and `stall=0`:
  - BRANCH with `ex_pred != ex_taken`, or
  - JAL or JALR.
- Outputs in IDLE:
  - `redir=1`: `pc_sel=0`, both flush codes 2'b11.
  - `stall=1`: `pc_sel=1`, `flush_if_id=2'b11`, `flush_id_ex=2'b10`.
  - Otherwise: `pc_sel=1`, both flush codes equal `flush_in`.
- FSM states: IDLE and SHADOW, with a 3-bit down-counter `sh_cnt`.
  - IDLE -> SHADOW on `redir` when SHADOW>0; load `sh_cnt=SHADOW-1`.
  - In SHADOW: `ex_valid` is ignored (wrong path), `pc_sel=1`, both flush codes 2'b11.
  - Each cycle in SHADOW, `sh_cnt` decrements; leave to IDLE on the cycle `sh_cnt==0`.
  - SHADOW=0: the FSM never leaves IDLE.
- BHT update, on the clock edge, in IDLE with `ex_valid=1`, `stall=0`, opcode BRANCH:
  - Index `ex_pc[IDX_W+1:2]`.
  - Taken: increment, saturating at 2'b11. Not taken: decrement, saturating at 2'b00.
  - JAL/JALR never update the BHT.
- Same-cycle collision: fetch lookup and update to the same index -> `pred_taken` uses the pre-update value; no bypass.

## Timing
- `pred_taken`, `pc_sel`, `redirect_pc` and the flush codes are combinational from current inputs and state; 0-cycle latency.
- BHT write takes effect one cycle after the resolving edge.
- Redirect penalty: 1 redirect cycle plus SHADOW flush cycles.
- Reset (`rst_n` low, asynchronous):
  - every counter = 2'b01 (weakly not-taken);
  - state = IDLE, `sh_cnt=0`;
  - stats = 0.
- Reset asserted mid-SHADOW: FSM returns to IDLE immediately; the flush hold is abandoned.
- Outputs during reset follow the IDLE rules above; `pred_taken=0`.
- `stall` and `redir` conditions are mutually exclusive by construction: `redir` requires `stall=0`.

## Configuration
- `BHT_STATS_EN` defined:
  - `branch_cnt` counts every BHT-updating branch.
  - `mispred_cnt` counts those with `ex_pred != ex_taken`.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- `BHT_STATS_EN` undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `fetch_pc=0x40` -> `pred_taken=0`. Resolve two taken BRANCHes at `ex_pc=0x40` -> counter 01->10->11; `pred_taken=1` from the cycle after the first update.
- BRANCH at `ex_pc=0x100`, `ex_pred=0`, `ex_taken=1`, `alu_target=0x200`, SHADOW=1:
  - redirect cycle: `pc_sel=0`, `redirect_pc=0x200`, flushes 2'b11;
  - next cycle: SHADOW with flushes 2'b11 and `ex_valid` ignored;
  - following cycle: IDLE.
- BRANCH with `ex_pred=1`, `ex_taken=0`, `ex_pc=0x80` -> `redirect_pc=0x84`, `pc_sel=0`; counter decrements once.
- Non-control instruction with `stall=1` -> `pc_sel=1`, `flush_if_id=2'b11`, `flush_id_ex=2'b10`, no BHT change. Same with `stall=0`, `flush_in=2'b01` -> both flush codes 2'b01.
- JAL during `stall=1` -> no redirect, no BHT/stat change. Deassert `stall` -> redirect to `alu_target`.
- Assert `rst_n` low during SHADOW=3 hold -> IDLE at once, all counters 01. With `BHT_STATS_EN`: 3 branches with 1 mispredict -> `branch_cnt=3`, `mispred_cnt=1`.
